// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller state encoding and default widths.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } mdu_state_e;

    // True for the op codes that start a multi-cycle calculation.
    function automatic logic is_arith_op(input logic [2:0] op_code);
        logic res;
        case (op_code)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: {acc, opq} is the 64-bit product/multiplier shift register,
//           opnd is the multiplicand.
// Divide:   acc is the partial remainder, opq shifts dividend bits out of
//           its MSB and quotient bits into its LSB, opnd is the divisor.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opq,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] opq_next
);

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   chosen_s;
    logic [WIDTH:0]   shifted_s;
    logic             no_borrow_s;
    logic [WIDTH-1:0] rem_sub_s;

    // Shift-add for multiply, trial subtract with restore for divide.
    always_comb begin
        add_s       = {1'b0, acc} + {1'b0, opnd};
        chosen_s    = {1'b0, acc};
        shifted_s   = {acc, opq[WIDTH-1]};
        // The partial remainder is always below the divisor, so the shifted
        // value is below twice the divisor and a wrapped WIDTH-bit
        // difference is exact whenever no borrow occurs.
        no_borrow_s = (shifted_s >= {1'b0, opnd});
        rem_sub_s   = shifted_s[WIDTH-1:0] - opnd;
        acc_next    = acc;
        opq_next    = opq;
        if (opq[0]) begin
            chosen_s = add_s;
        end else begin
            chosen_s = {1'b0, acc};
        end
        if (is_div) begin
            if (no_borrow_s) begin
                acc_next = rem_sub_s;
            end else begin
                acc_next = shifted_s[WIDTH-1:0];
            end
            opq_next = {opq[WIDTH-2:0], no_borrow_s};
        end else begin
            acc_next = chosen_s[WIDTH:1];
            opq_next = {chosen_s[0], opq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated for WIDTH
// cycles in CALC, then sign-corrected and written to HI/LO in SIGN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = {CNT_W{1'b1}};

    mdu_state_e       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_r, opq_r, opnd_r;
    logic [WIDTH-1:0] acc_step_s, opq_step_s;
    logic             is_div_r, res_neg_r, rem_neg_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;
    logic             busy_next_s, done_next_s;

    logic             accept_s, signed_op_s, div_op_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .opq      (opq_r),
        .opnd     (opnd_r),
        .acc_next (acc_step_s),
        .opq_next (opq_step_s)
    );

    // Request decode and operand magnitudes for the accepting edge.
    always_comb begin
        accept_s    = start && (state_r == ST_IDLE) && is_arith_op(op);
        signed_op_s = (op == OP_MULT) || (op == OP_DIV);
        div_op_s    = (op == OP_DIV) || (op == OP_DIVU);
        if (signed_op_s && a[WIDTH-1]) begin
            mag_a_s = ZERO_W - a;
        end else begin
            mag_a_s = a;
        end
        if (signed_op_s && b[WIDTH-1]) begin
            mag_b_s = ZERO_W - b;
        end else begin
            mag_b_s = b;
        end
    end

    // Sign fixup applied to the magnitude results in the SIGN cycle.
    always_comb begin
        if (res_neg_r) begin
            prod_fix_s = ZERO_2W - {acc_r, opq_r};
            quo_fix_s  = ZERO_W - opq_r;
        end else begin
            prod_fix_s = {acc_r, opq_r};
            quo_fix_s  = opq_r;
        end
        if (rem_neg_r) begin
            rem_fix_s = ZERO_W - acc_r;
        end else begin
            rem_fix_s = acc_r;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_SIGN;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_SIGN: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Controller outputs, computed one cycle ahead so they can be registered.
    always_comb begin
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_r == ST_SIGN);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Datapath registers, iteration counter and HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= CNT_ZERO;
            acc_r     <= ZERO_W;
            opq_r     <= ZERO_W;
            opnd_r    <= ZERO_W;
            is_div_r  <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= CNT_ZERO;
                        acc_r    <= ZERO_W;
                        opq_r    <= mag_a_s;
                        opnd_r   <= mag_b_s;
                        is_div_r <= div_op_s;
                        // Divide by zero must leave an all-ones quotient
                        // regardless of operand signs, so its sign is forced
                        // positive; a zero product is unaffected either way.
                        res_neg_r <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1])
                                     && (b != ZERO_W);
                        rem_neg_r <= signed_op_s && div_op_s && a[WIDTH-1];
                    end else if (start && (op == OP_MTHI)) begin
                        hi_r <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        lo_r <= a;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_step_s;
                    opq_r <= opq_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                ST_SIGN: begin
                    if (is_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random operations
// against an arithmetic reference model, plus handshake/reset scenarios.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; return p; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy; r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue one arithmetic op; report edges from acceptance to done and busy samples.
    task automatic do_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         output int lat, output int bcyc);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0; bcyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        // rst wins over a simultaneous MTHI
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [2:0]  dop [10] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd0, 3'd3};
        logic [31:0] da  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        logic [31:0] db  [10] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0,
                                  32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd9};
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int lat, bcyc;
        for (int i = 0; i < 50; i++) begin
            if (i < 10) begin
                o = dop[i]; x = da[i]; y = db[i];
            end else begin
                o = 3'($urandom_range(0, 3));
                x = $urandom;
                y = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            exp = ref_model(o, x, y);
            do_op(o, x, y, lat, bcyc);
            checks++;
            if (lat != 33 || bcyc != 33 || busy !== 1'b0) begin
                failures++;
                $display("FAIL latency op=%0d a=%h b=%h lat=%0d busy_cycles=%0d busy=%b required 33/33/0",
                         o, x, y, lat, bcyc, busy);
            end
            checks++;
            if ({hi, lo} !== exp) begin
                failures++;
                $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h",
                         o, x, y, hi, lo, exp[63:32], exp[31:0]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse op=%0d done=%b required 0", o, done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;           // accepted here (E0)
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (n == 5) begin start = 1'b1; op = 3'd1; a = 32'd9;      b = 32'd9; end
            else if (n == 9) begin start = 1'b1; op = 3'd4; a = 32'h1234; end
            else if (n == 31) begin start = 1'b1; op = 3'd5; a = 32'h5555; end
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        checks++;
        if (n != 33 || hi !== 32'd0 || lo !== 32'd42) begin
            failures++;
            $display("FAIL busy_ignore lat=%0d hi=%h lo=%h required 33/0/2a", n, hi, lo);
        end
        // MTLO right after done: visible next cycle, no done
        start = 1'b1; op = 3'd5; a = 32'hABCD;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (lo !== 32'hABCD || done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0) begin
            failures++;
            $display("FAIL mtlo lo=%h done=%b busy=%b hi=%h required abcd/0/0/0", lo, done, busy, hi);
        end
        start = 1'b1; op = 3'd4; a = 32'h0F0F_0001;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (hi !== 32'h0F0F_0001 || lo !== 32'hABCD || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi hi=%h lo=%h busy=%b required 0f0f0001/abcd/0", hi, lo, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; a = 32'd10; b = 32'd11;
        @(posedge clk); #1;           // E0, start stays high
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 33 || busy !== 1'b0 || lo !== 32'd110) begin
            failures++;
            $display("FAIL b2b_first lat=%0d busy=%b lo=%h required 33/0/6e", n, busy, lo);
        end
        a = 32'd12; b = 32'd13;
        @(posedge clk); #1;           // E34 accepts the held request
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept busy=%b done=%b required 1/0", busy, done);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 33 || lo !== 32'd156 || hi !== 32'd0) begin
            failures++;
            $display("FAIL b2b_second lat=%0d hi=%h lo=%h required 33/0/9c", n, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int seen, lat, bcyc;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_abort activity_cycles=%0d required 0", seen);
        end
        do_op(3'd1, 32'd3, 32'd4, lat, bcyc);
        checks++;
        if (lat != 33 || lo !== 32'd12 || hi !== 32'd0) begin
            failures++;
            $display("FAIL after_reset lat=%0d hi=%h lo=%h required 33/0/c", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
